// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, divider formula, data width
// Purpose: common constants for uart_send / uart_recv so both ends agree on
//          framing and on how the baud divider is derived.
// Ports:   none (package).
package uart_pkg;

  localparam int DATA_BITS = 8;

  // State encoding kept as plain localparams so other blocks can reuse it.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    STOP   = ST_STOP,
    PARITY = ST_PARITY
  } uart_state_t;

  // Clocks per bit; integer divide, identical on transmit and receive side.
  function automatic int baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_recv_if.sv
// rtl/uart_recv_if.sv - receive-side pin and user-logic signal bundle
// Purpose: groups the serial input and the byte/strobe outputs of uart_recv.
// Signals: uart_rxd (pin, idle high), uart_rx_data[7:0], uart_rx_done,
//          uart_rx_busy, uart_frame_err, uart_parity_err (only with UART_RX_PARITY_EN).
// Modports: slave = the receiver, master = the environment driving the pin.
interface uart_recv_if;
  import uart_pkg::*;

  logic                 uart_rxd;
  logic [DATA_BITS-1:0] uart_rx_data;
  logic                 uart_rx_done;
  logic                 uart_rx_busy;
  logic                 uart_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 uart_parity_err;
`endif

  modport slave (
    input  uart_rxd,
    output uart_rx_data,
    output uart_rx_done,
    output uart_rx_busy,
`ifdef UART_RX_PARITY_EN
    output uart_parity_err,
`endif
    output uart_frame_err
  );

  modport master (
    output uart_rxd,
    input  uart_rx_data,
    input  uart_rx_done,
    input  uart_rx_busy,
`ifdef UART_RX_PARITY_EN
    input  uart_parity_err,
`endif
    input  uart_frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with falling-edge detect
// Purpose: brings the asynchronous RX pin into the clk domain and flags
//          high-to-low transitions of the synchronised level.
// Ports: clk, rst_n (async active-low), din (async pin),
//        dout (synchronised level), fall (one-cycle high-to-low flag).
// All flops reset to 1 so a line that idles high never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic r_s1;
  logic r_s2;
  logic r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_d  <= 1'b1;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  assign dout = r_s2;
  assign fall = r_d & ~r_s2;

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - UART receiver, 8 data bits, LSB first, one stop bit
// Purpose: detects the start bit, samples each bit at mid-point, checks the
//          stop bit and presents the byte with a one-cycle done strobe.
// Ports: clk, rst_n (async active-low), rx (uart_recv_if.slave):
//        uart_rxd in; uart_rx_data, uart_rx_done, uart_rx_busy,
//        uart_frame_err (and uart_parity_err) out.
// Optional: UART_RX_PARITY_EN adds a parity bit before the stop bit,
//           parameter PARITY_ODD and output uart_parity_err.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic         clk,
  input logic         rst_n,
  uart_recv_if.slave  rx
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int BAUD_HALF    = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BIT_END  = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_HALF - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  logic w_rxd;
  logic w_fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx.uart_rxd),
    .dout  (w_rxd),
    .fall  (w_fall)
  );

  uart_state_t          r_state;
  logic [15:0]          r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_perr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_baud_cnt <= 16'd0;
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit in; a high level means the edge was noise.
        START: begin
          if (r_baud_cnt == HALF_END) begin
            r_baud_cnt <= 16'd0;
            if (!w_rxd) begin
              r_state   <= DATA;
              r_bit_cnt <= 4'd0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        // Right shift: first (LSB) bit ends up in bit 0 after the last sample.
        DATA: begin
          if (r_baud_cnt == BIT_END) begin
            r_baud_cnt <= 16'd0;
            r_shift    <= {w_rxd, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_baud_cnt == BIT_END) begin
            r_baud_cnt <= 16'd0;
            r_par_bit  <= w_rxd;
            r_state    <= STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
`endif

        // Leave at mid-stop-bit so a start edge half a bit later is still caught.
        STOP: begin
          if (r_baud_cnt == BIT_END) begin
            r_baud_cnt <= 16'd0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            if (!w_rxd) begin
              r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bit != ((^r_shift) ^ PARITY_ODD)) begin
              r_perr <= 1'b1;
`endif
            end else begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign rx.uart_rx_data   = r_data;
  assign rx.uart_rx_done   = r_done;
  assign rx.uart_rx_busy   = r_busy;
  assign rx.uart_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign rx.uart_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - scoreboard bench for uart_recv
module tb_uart_recv;

  localparam int CLK_FREQ   = 50000000;
  localparam int UART_BPS   = 115200;
  localparam int BAUD       = CLK_FREQ / UART_BPS;
  localparam int HALF       = BAUD / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PODD       = 1'b0;
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  uart_recv_if rx_if ();

  uart_recv #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD (PODD)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  logic [7:0] last_good = 8'h00;
  int         cyc = 0;
  int         prev_done_cyc = 0;
  int         last_done_cyc = 0;

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, req, req, $time);
    end
  endfunction

  function automatic logic good_par(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ PODD;
`else
    return ^d;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest expected frame outcome.
  always @(negedge clk) begin
    logic perr;
    int   act_kind;
    exp_t e;
`ifdef UART_RX_PARITY_EN
    perr = rx_if.uart_parity_err;
`else
    perr = 1'b0;
`endif
    if (rst_n && (rx_if.uart_rx_done || rx_if.uart_frame_err || perr)) begin
      chk("pulse_exclusive", int'(rx_if.uart_rx_done) + int'(rx_if.uart_frame_err) + int'(perr), 1);
      act_kind = rx_if.uart_rx_done ? K_DONE : (rx_if.uart_frame_err ? K_FERR : K_PERR);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", act_kind, -1);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", act_kind, e.kind);
        if (act_kind == K_DONE) begin
          chk("rx_data", int'(rx_if.uart_rx_data), int'(e.data));
          chk("busy_at_done", int'(rx_if.uart_rx_busy), 0);
          last_good = e.data;
          prev_done_cyc = last_done_cyc;
          last_done_cyc = cyc;
        end else begin
          chk("data_held_on_err", int'(rx_if.uart_rx_data), int'(last_good));
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx_if.uart_rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    exp_t e;
    e.data = d;
    e.kind = K_DONE;
`ifdef UART_RX_PARITY_EN
    if (par_b != good_par(d)) e.kind = K_PERR;
`endif
    if (!stop_b) e.kind = K_FERR;
    exp_q.push_back(e);
    drive_bit(1'b0, BAUD);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BAUD);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, BAUD);
`endif
    drive_bit(stop_b, BAUD);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3 * FRAME_BITS * BAUD) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, int'(rx_if.uart_rx_data), 0);
    chk({tag, "_done"}, int'(rx_if.uart_rx_done), 0);
    chk({tag, "_busy"}, int'(rx_if.uart_rx_busy), 0);
    chk({tag, "_ferr"}, int'(rx_if.uart_frame_err), 0);
  endtask

  initial begin
    int         busy_w;
    logic [7:0] d;
    logic       sb;
    logic       pb;

    rx_if.uart_rxd = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Short low glitch: START must abort after half a bit, with no pulses.
    busy_w = 0;
    rx_if.uart_rxd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_if.uart_rx_busy) busy_w++;
    end
    rx_if.uart_rxd = 1'b1;
    for (int i = 0; i < 2 * BAUD; i++) begin
      @(negedge clk);
      if (rx_if.uart_rx_busy) busy_w++;
    end
    chk("glitch_busy_width", busy_w, HALF);
    chk("glitch_data", int'(rx_if.uart_rx_data), 0);

    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    drive_bit(1'b1, BAUD);
    drain("a5");

    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    drive_bit(1'b1, BAUD);
    drain("3c_ferr");
    chk("data_after_ferr", int'(rx_if.uart_rx_data), 8'hA5);

    // Back-to-back frames with no idle between stop and next start.
    send_frame(8'h00, 1'b1, good_par(8'h00));
    send_frame(8'hFF, 1'b1, good_par(8'hFF));
    drive_bit(1'b1, BAUD);
    drain("b2b");
    chk("b2b_spacing", last_done_cyc - prev_done_cyc, FRAME_BITS * BAUD);
    chk("b2b_last_data", int'(rx_if.uart_rx_data), 8'hFF);

    // Reset in the middle of data bit 4 of 8'h55; the partial byte is dropped.
    d = 8'h55;
    drive_bit(1'b0, BAUD);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BAUD);
    drive_bit(d[4], HALF);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    last_good = 8'h00;
    exp_q.delete();
    rx_if.uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b1, BAUD);
    send_frame(8'h81, 1'b1, good_par(8'h81));
    drive_bit(1'b1, BAUD);
    drain("81");

    // Break: line stuck low for longer than a frame gives one frame error only.
    begin
      exp_t e;
      e.kind = K_FERR;
      e.data = 8'h00;
      exp_q.push_back(e);
    end
    drive_bit(1'b0, (FRAME_BITS + 3) * BAUD);
    drive_bit(1'b1, 2 * BAUD);
    drain("break");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1, BAUD);
    drain("par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, BAUD);
    drain("par_good");
`endif

    // Randomised frames; a bad stop bit is always followed by some idle so the
    // next start bit produces a real falling edge.
    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, sb, pb);
      if (sb) drive_bit(1'b1, $urandom_range(0, BAUD));
      else    drive_bit(1'b1, $urandom_range(10, BAUD));
    end
    drive_bit(1'b1, BAUD);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
